// File: rtl/peak_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : peak_search_ctrl
// Purpose  : Frame sequencer that collects K samples per frame and reports the
//            largest non-negative sample, its position and the count of
//            non-negative samples. Define PEAK_INDEX_EN to keep the index datapath.
// Revision : 1.0
// ============================================================================
module peak_search_ctrl #(
    parameter int N  = 16,
    parameter int K  = 42,
    parameter int IW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic          in_valid,
    input  logic [N-1:0]  in_data,
    output logic          in_ready,
    output logic          busy,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_peak,
    output logic [IW-1:0] out_index,
    output logic [IW:0]   out_count,
    output logic          out_none
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_REPORT  = 2'd2
    } state_t;

    localparam logic [IW-1:0] LAST_POS = IW'(K - 1);

    state_t        state_q, state_d;
    logic [IW-1:0] pos_q, pos_d;
    logic [N-1:0]  max_q, max_d;
    logic [IW:0]   cnt_q, cnt_d;
    logic          none_q, none_d;
    logic          w_xfer;
    logic          w_take;

    // Abort wins over a same-cycle sample, so it gates the transfer itself.
    assign w_xfer = (state_q == S_COLLECT) && in_valid && !abort;
    // Both operands are non-negative, so an unsigned compare of the low bits suffices.
    assign w_take = w_xfer && !in_data[N-1] &&
                    (none_q || (in_data[N-2:0] > max_q[N-2:0]));

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        max_d   = max_q;
        cnt_d   = cnt_q;
        none_d  = none_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_COLLECT;
                    pos_d   = '0;
                    max_d   = '0;
                    cnt_d   = '0;
                    none_d  = 1'b1;
                end
            end
            S_COLLECT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (in_valid) begin
                    pos_d = pos_q + 1'b1;
                    if (!in_data[N-1]) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (w_take) begin
                        max_d  = in_data;
                        none_d = 1'b0;
                    end
                    if (pos_q == LAST_POS) begin
                        state_d = S_REPORT;
                    end
                end
            end
            S_REPORT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pos_q   <= '0;
            max_q   <= '0;
            cnt_q   <= '0;
            none_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            max_q   <= max_d;
            cnt_q   <= cnt_d;
            none_q  <= none_d;
        end
    end

`ifdef PEAK_INDEX_EN
    logic [IW-1:0] idx_q, idx_d;

    always_comb begin
        idx_d = idx_q;
        if (state_q == S_IDLE && start) begin
            idx_d = '0;
        end else if (w_take) begin
            idx_d = pos_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign out_index = idx_q;
`else
    assign out_index = '0;
`endif

    assign in_ready  = (state_q == S_COLLECT);
    assign busy      = (state_q == S_COLLECT) || (state_q == S_REPORT);
    assign out_valid = (state_q == S_REPORT);
    assign out_peak  = max_q;
    assign out_count = cnt_q;
    assign out_none  = none_q;

endmodule
`default_nettype wire

// File: tb/tb_peak_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_peak_search_ctrl
// Purpose  : Directed self-checking bench for peak_search_ctrl with N=16, K=4, IW=2.
// Revision : 1.0
// ============================================================================
module tb_peak_search_ctrl;

    localparam int N  = 16;
    localparam int K  = 4;
    localparam int IW = 2;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic          in_valid;
    logic [N-1:0]  in_data;
    logic          in_ready;
    logic          busy;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_peak;
    logic [IW-1:0] out_index;
    logic [IW:0]   out_count;
    logic          out_none;

    int total = 0;
    int bad   = 0;

    peak_search_ctrl #(.N(N), .K(K), .IW(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_peak  (out_peak),
        .out_index (out_index),
        .out_count (out_count),
        .out_none  (out_none)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // The index datapath only exists when PEAK_INDEX_EN is defined.
    function automatic logic [31:0] ei(input int v);
`ifdef PEAK_INDEX_EN
        return 32'(v);
`else
        return 32'(v & 0);
`endif
    endfunction

    task automatic chk_result(input string tag, input logic [15:0] pk, input int ix,
                              input int cn, input logic nn);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".peak"},  32'(out_peak),  32'(pk));
        chk({tag, ".index"}, 32'(out_index), ei(ix));
        chk({tag, ".count"}, 32'(out_count), 32'(cn));
        chk({tag, ".none"},  32'(out_none),  32'(nn));
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start.in_ready", 32'(in_ready), 32'd1);
        chk("start.busy",     32'(busy),     32'd1);
    endtask

    // Feeds one frame; with gaps, in_valid drops every other cycle carrying a bait value.
    task automatic feed(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                        input logic [15:0] d, input bit gaps);
        logic [15:0] s [4];
        s[0] = a; s[1] = b; s[2] = c; s[3] = d;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = s[i];
            @(negedge clk);
            if (gaps && i < 3) begin
                in_valid = 1'b0;
                in_data  = 16'h7FFE;
                @(negedge clk);
                chk("gap.in_ready", 32'(in_ready), 32'd1);
            end
            if (i == 2) chk("pre_last.valid", 32'(out_valid), 32'd0);
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ".hs_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".hs_busy"},  32'(busy),      32'd0);
    endtask

    initial begin
        rst_n     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #1 rst_n  = 1'b0;
        #1;
        chk("rst.in_ready",  32'(in_ready),  32'd0);
        chk("rst.busy",      32'(busy),      32'd0);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.peak",      32'(out_peak),  32'd0);
        chk("rst.index",     32'(out_index), 32'd0);
        chk("rst.count",     32'(out_count), 32'd0);
        chk("rst.none",      32'(out_none),  32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic frame
        do_start();
        feed(16'd5, 16'd300, 16'd7, 16'd12, 1'b0);
        chk_result("basic", 16'd300, 1, 4, 1'b0);
        handshake("basic");

        // Negatives filtered, tie keeps earliest position; back-to-back start
        do_start();
        feed(16'h8001, 16'd9, 16'hFFFF, 16'd9, 1'b0);
        chk_result("tie", 16'd9, 1, 2, 1'b0);
        handshake("tie");

        // All negative
        do_start();
        feed(16'h8000, 16'hFFF0, 16'hC000, 16'h9000, 1'b0);
        chk_result("allneg", 16'd0, 0, 0, 1'b1);
        handshake("allneg");

        // Stalls on input, backpressure on output; start/abort ignored in REPORT
        do_start();
        feed(16'd3, 16'h7FFF, 16'h7FFF, 16'd1, 1'b1);
        chk_result("stall", 16'h7FFF, 1, 4, 1'b0);
        start = 1'b1;
        abort = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_result("hold", 16'h7FFF, 1, 4, 1'b0);
        end
        start = 1'b0;
        abort = 1'b0;
        handshake("stall");

        // Abort after two transfers, with a concurrent sample that must be dropped
        do_start();
        in_valid = 1'b1;
        in_data  = 16'd100;
        @(negedge clk);
        in_data  = 16'd200;
        @(negedge clk);
        in_data  = 16'd500;
        abort    = 1'b1;
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("abort.busy",     32'(busy),      32'd0);
        chk("abort.in_ready", 32'(in_ready),  32'd0);
        chk("abort.valid",    32'(out_valid), 32'd0);
        repeat (3) @(negedge clk);
        chk("abort.idle_valid", 32'(out_valid), 32'd0);
        do_start();
        feed(16'd1, 16'd2, 16'd3, 16'd4, 1'b0);
        chk_result("after_abort", 16'd4, 3, 4, 1'b0);
        handshake("after_abort");

        // Asynchronous reset mid-COLLECT
        do_start();
        in_valid = 1'b1;
        in_data  = 16'd77;
        @(negedge clk);
        in_data  = 16'd88;
        #2 rst_n = 1'b0;
        #1;
        chk("arst.in_ready",  32'(in_ready),  32'd0);
        chk("arst.busy",      32'(busy),      32'd0);
        chk("arst.out_valid", 32'(out_valid), 32'd0);
        chk("arst.peak",      32'(out_peak),  32'd0);
        chk("arst.index",     32'(out_index), 32'd0);
        chk("arst.count",     32'(out_count), 32'd0);
        chk("arst.none",      32'(out_none),  32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst.post_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/peak_search_ctrl.md
# peak_search_ctrl

Frame-based sequencer for peak search over a signed sample stream. It accepts exactly K samples per frame under a valid/ready handshake and discards negative samples (MSB set). It tracks the largest non-negative sample and its position in the frame, then presents the result on a held valid/ready output port. It sits between the sample source and downstream consumers, and owns start, abort and frame counting, so the peak datapath never runs unframed.

## Interface
- N, 16, sample width in bits (two's complement)
- K, 42, samples per frame (K ≥ 2)
- IW, 6, index width; must satisfy 2^IW ≥ K
- clk  input  1  single clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a frame; sampled only in IDLE
- abort  input  1  abandon the current frame; sampled only in COLLECT
- in_valid  input  1  in_data valid this cycle
- in_data  input  N  signed sample
- in_ready  output  1  block accepts a sample this cycle
- busy  output  1  high in COLLECT or REPORT
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- out_peak  output  N  largest non-negative sample, 0 if none
- out_index  output  IW  frame position (0..K-1) of out_peak
- out_count  output  IW+1  number of non-negative samples in the frame
- out_none  output  1  frame contained no non-negative sample

## Operation
- States: IDLE, COLLECT, REPORT.
- IDLE
  - in_ready=0, out_valid=0.
  - start=1 → COLLECT. On entry, clear: position counter pos=0, max=0, idx=0, cnt=0, found=0.
- COLLECT
  - in_ready=1. A transfer occurs when in_valid & in_ready.
  - Per transfer: if in_data[N-1]==0, then cnt+=1, and if (!found or in_data > max) then max=in_data, idx=pos, found=1.
  - Ties keep the earliest position. Negative samples only advance pos.
  - Every transfer increments pos.
  - The transfer at pos==K-1 → REPORT.
  - abort=1 → IDLE. The same-cycle sample is dropped and no result is produced. abort has priority over a concurrent transfer.
- REPORT
  - out_valid=1. out_peak, out_index, out_count and out_none hold stable until out_valid & out_ready; then → IDLE.
  - start and abort are ignored here.
- The comparison is magnitude on N-1 bits; both operands are known non-negative. No arithmetic widening is needed.
- out_none = !found. When out_none=1: out_peak=0, out_index=0, out_count=0.
- Reset (any state, any time): state=IDLE. All outputs 0: in_ready, busy, out_valid, out_peak, out_index, out_count, out_none. An in-flight frame is lost.

## Timing
- in_ready, busy and out_valid decode from the registered state; there is no input-to-output combinational path.
- Result registers update on the clock edge of each accepted sample.
- out_valid rises the cycle after the K-th transfer.
- Minimum frame: 1 cycle start + K cycles of transfers + 1 cycle handshake (out_ready held high) = K+2 cycles from start to IDLE.
- in_valid gaps stall the frame indefinitely; pos does not advance.
- out_ready low holds REPORT indefinitely with outputs unchanged.
- A start asserted in the IDLE cycle after a REPORT handshake begins a new frame immediately. Back-to-back throughput is one frame per K+2 cycles.

## Configuration
- PEAK_INDEX_EN defined: the pos/idx registers feed out_index as described.
- PEAK_INDEX_EN undefined: idx logic is removed and out_index is tied to 0. The port remains. pos counting for frame length is unchanged.

## Test plan
- Parameter set for all scenarios: N=16, K=4, IW=2.
- Basic: start, then samples 5, 300, 7, 12 → out_valid 1 cycle after the 4th transfer; out_peak=300, out_index=1, out_count=4, out_none=0.
- Negatives filtered, tie: 0x8001, 9, 0xFFFF, 9 → out_peak=9, out_index=1, out_count=2.
- All negative: 0x8000, 0xFFF0, 0xC000, 0x9000 → out_none=1, out_peak=0, out_index=0, out_count=0.
- Stall and backpressure: in_valid toggling every other cycle, out_ready held low 5 cycles → correct peak; outputs are constant while out_valid=1 and out_ready=0; return to IDLE on the handshake cycle.
- Abort and reset:
  - abort after 2 transfers → IDLE with no out_valid; the next frame 1, 2, 3, 4 reports out_peak=4, out_index=3.
  - rst_n pulsed low mid-COLLECT → all outputs 0 immediately, asynchronously.
